// File: rtl/uncached_dbus_bridge_pkg.sv
// uncached_dbus_bridge_pkg: shared data-bus and cache-bus request/response types
package uncached_dbus_bridge_pkg;
  typedef enum logic [2:0] {MSIZE1, MSIZE2, MSIZE4, MSIZE8} msize_t;
  typedef enum logic [3:0] {MLEN1 = 4'd0, MLEN2 = 4'd1, MLEN4 = 4'd3, MLEN8 = 4'd7, MLEN16 = 4'd15} mlen_t;
  typedef enum logic [1:0] {AXI_BURST_FIXED, AXI_BURST_INCR, AXI_BURST_WRAP} axi_burst_type_t;
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;
  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;
  typedef struct packed {
    logic            valid;
    logic            is_write;
    msize_t          size;
    logic [63:0]     addr;
    logic [7:0]      strobe;
    logic [63:0]     data;
    mlen_t           len;
    axi_burst_type_t burst;
  } cbus_req_t;
  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;
endpackage

// File: rtl/uncached_dbus_bridge_watchdog.sv
// bus_watchdog: saturating wait counter that flags the last permitted idle cycle
module bus_watchdog #(
  parameter int LIMIT = 8,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic timeout
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (reset || clr) cnt <= '0;
    else if (en && cnt != CNT_W'(LIMIT)) cnt <= cnt + CNT_W'(1);
  end
  assign timeout = en && cnt >= CNT_W'(LIMIT - 1);
endmodule

// File: rtl/uncached_dbus_bridge.sv
// uncached_dbus_bridge: turns one uncached CPU data-bus access into one single-beat cbus transaction
module uncached_dbus_bridge
  import uncached_dbus_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 0,
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output cbus_req_t  creq,
  input  cbus_resp_t cresp,
  output logic       bus_err
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [63:0] addr_q, data_q, rbuf;
  msize_t size_q;
  logic [7:0] strobe_q;
  logic err_q, accept, done, timeout, is_write;
  assign is_write = |strobe_q;
  assign accept = state == IDLE && dreq.valid;
  assign done = state == WAIT && cresp.ready && cresp.last;
  generate
    if (TIMEOUT_CYCLES > 0) begin : g_wd
      bus_watchdog #(.LIMIT(TIMEOUT_CYCLES), .CNT_W(CNT_W)) u_wd (
        .clk(clk),
        .reset(reset),
        .clr(accept),
        .en(state == WAIT && !cresp.ready),
        .timeout(timeout)
      );
    end else begin : g_no_wd
      assign timeout = 1'b0;
    end
  endgenerate
  always_comb begin
    state_n = state == IDLE ? (dreq.valid ? WAIT : IDLE)
            : state == WAIT ? ((done || timeout) ? RESP : WAIT)
            : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      addr_q <= '0;
      data_q <= '0;
      size_q <= MSIZE1;
      strobe_q <= '0;
      rbuf <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        addr_q <= dreq.addr;
        data_q <= dreq.data;
        size_q <= dreq.size;
        strobe_q <= dreq.strobe;
      end
      if (done) begin
        rbuf <= is_write ? '0 : cresp.data;
        err_q <= 1'b0;
      end else if (timeout) begin
        rbuf <= '1;
        err_q <= 1'b1;
      end
    end
  end
  always_comb begin
    creq = '0;
    if (state == WAIT) begin
      creq.valid = 1'b1;
      creq.is_write = is_write;
      creq.size = size_q;
      creq.addr = addr_q;
      creq.strobe = strobe_q;
      creq.data = is_write ? data_q : '0;
      creq.len = MLEN1;
      creq.burst = AXI_BURST_FIXED;
    end
  end
  always_comb begin
    dresp = '0;
    dresp.addr_ok = state == RESP;
    dresp.data_ok = state == RESP;
    dresp.data = state == RESP ? rbuf : '0;
  end
  assign bus_err = state == RESP && err_q;
endmodule

// File: tb/tb_uncached_dbus_bridge.sv
// tb_uncached_dbus_bridge: directed checks of read, write, back-to-back, timeout, reset and stability
module tb_uncached_dbus_bridge;
  import uncached_dbus_bridge_pkg::*;
  logic clk = 1'b0;
  logic reset;
  dbus_req_t dreq;
  dbus_resp_t dresp;
  cbus_req_t creq;
  cbus_resp_t cresp;
  logic bus_err;
  int tests = 0;
  int fails = 0;
  uncached_dbus_bridge #(.TIMEOUT_CYCLES(8), .CNT_W(16)) dut (
    .clk(clk),
    .reset(reset),
    .dreq(dreq),
    .dresp(dresp),
    .creq(creq),
    .cresp(cresp),
    .bus_err(bus_err)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic ready_beat(input logic [63:0] d);
    cresp.ready = 1'b1;
    cresp.last = 1'b1;
    cresp.data = d;
  endtask
  initial begin
    logic [5:0] vpat, opat;
    reset = 1'b1;
    dreq = '0;
    cresp = '0;
    step();
    step();
    check("rst_creq_valid", creq.valid, 0);
    check("rst_dresp", dresp, 0);
    check("rst_bus_err", bus_err, 0);
    reset = 1'b0;
    step();
    check("idle_creq_valid", creq.valid, 0);
    // read with three empty wait cycles
    dreq.valid = 1'b1;
    dreq.addr = 64'h4000_0008;
    dreq.size = MSIZE4;
    dreq.strobe = 8'h00;
    dreq.data = 64'hAAAA_BBBB_CCCC_DDDD;
    step();
    check("rd_creq_valid", creq.valid, 1);
    check("rd_is_write", creq.is_write, 0);
    check("rd_len", creq.len, MLEN1);
    check("rd_burst", creq.burst, AXI_BURST_FIXED);
    check("rd_strobe", creq.strobe, 0);
    check("rd_data", creq.data, 0);
    check("rd_addr", creq.addr, 64'h4000_0008);
    check("rd_size", creq.size, MSIZE4);
    step();
    step();
    step();
    check("rd_no_early_ok", dresp.data_ok, 0);
    ready_beat(64'h1122_3344_5566_7788);
    step();
    cresp = '0;
    check("rd_data_ok", dresp.data_ok, 1);
    check("rd_addr_ok", dresp.addr_ok, 1);
    check("rd_rdata", dresp.data, 64'h1122_3344_5566_7788);
    check("rd_bus_err", bus_err, 0);
    check("rd_resp_creq", creq.valid, 0);
    dreq.valid = 1'b0;
    step();
    check("rd_one_cycle", dresp.data_ok, 0);
    // write completing in the first wait cycle
    dreq.valid = 1'b1;
    dreq.addr = 64'h4000_0010;
    dreq.size = MSIZE8;
    dreq.strobe = 8'hF0;
    dreq.data = 64'hDEAD_BEEF_0000_0000;
    step();
    check("wr_is_write", creq.is_write, 1);
    check("wr_strobe", creq.strobe, 8'hF0);
    check("wr_data", creq.data, 64'hDEAD_BEEF_0000_0000);
    ready_beat(64'h1234_5678_9ABC_DEF0);
    step();
    cresp = '0;
    dreq.valid = 1'b0;
    check("wr_data_ok", dresp.data_ok, 1);
    check("wr_rdata_zero", dresp.data, 0);
    step();
    check("wr_done_idle", dresp.data_ok, 0);
    // back-to-back with request and ready held high
    dreq.valid = 1'b1;
    dreq.addr = 64'h4000_0020;
    dreq.size = MSIZE4;
    dreq.strobe = 8'h00;
    ready_beat(64'h0000_0000_0000_0042);
    vpat = '0;
    opat = '0;
    for (int i = 0; i < 6; i++) begin
      step();
      vpat[5-i] = creq.valid;
      opat[5-i] = dresp.data_ok;
    end
    check("b2b_creq_pattern", vpat, 6'b100100);
    check("b2b_ok_pattern", opat, 6'b010010);
    dreq.valid = 1'b0;
    cresp = '0;
    step();
    check("b2b_quiet", creq.valid, 0);
    // timeout with no ready
    dreq.valid = 1'b1;
    dreq.addr = 64'h4000_0030;
    step();
    for (int i = 0; i < 7; i++) begin
      step();
      check("to_waiting", {creq.valid, dresp.data_ok}, 2'b10);
    end
    step();
    dreq.valid = 1'b0;
    check("to_bus_err", bus_err, 1);
    check("to_data_ok", dresp.data_ok, 1);
    check("to_data", dresp.data, 64'hFFFF_FFFF_FFFF_FFFF);
    check("to_creq_drop", creq.valid, 0);
    step();
    check("to_err_pulse", {bus_err, dresp.data_ok}, 2'b00);
    // ready arriving in the eighth wait cycle beats the timeout
    dreq.valid = 1'b1;
    step();
    for (int i = 0; i < 7; i++) step();
    ready_beat(64'h0000_0000_0000_0055);
    step();
    cresp = '0;
    dreq.valid = 1'b0;
    check("race_bus_err", bus_err, 0);
    check("race_data", dresp.data, 64'h55);
    check("race_data_ok", dresp.data_ok, 1);
    step();
    // reset mid-wait
    dreq.valid = 1'b1;
    dreq.addr = 64'h4000_0040;
    step();
    check("rw_creq_before", creq.valid, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rw_creq_after", creq.valid, 0);
    check("rw_dresp", dresp, 0);
    check("rw_bus_err", bus_err, 0);
    step();
    check("rw_reissue", creq.valid, 1);
    ready_beat(64'h0000_0000_CAFE_F00D);
    step();
    cresp = '0;
    dreq.valid = 1'b0;
    check("rw_rdata", dresp.data, 64'hCAFE_F00D);
    step();
    // latched fields stay put while the CPU side wiggles
    dreq.valid = 1'b1;
    dreq.addr = 64'h4000_0050;
    dreq.strobe = 8'h0F;
    dreq.data = 64'h0000_0000_1357_9BDF;
    step();
    for (int i = 0; i < 3; i++) begin
      dreq.addr = 64'h9000_0000 + 64'(i);
      dreq.data = 64'hFFFF_0000 + 64'(i);
      dreq.strobe = 8'hFF;
      step();
      check("st_addr", creq.addr, 64'h4000_0050);
      check("st_data", creq.data, 64'h1357_9BDF);
      check("st_strobe", creq.strobe, 8'h0F);
    end
    ready_beat('0);
    step();
    cresp = '0;
    dreq.valid = 1'b0;
    check("st_data_ok", dresp.data_ok, 1);
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
